// File: rtl/sobel_ctrl_pkg.sv
// Shared types and kernel constants for the sobel frame controller.
// Weights are row-major; index 0 is the oldest (top-left) window pixel.
package sobel_ctrl_pkg;

   typedef enum logic [1:0] {
      K_GX    = 2'd0,
      K_GY    = 2'd1,
      K_IDENT = 2'd2,
      K_LAPL  = 2'd3
   } kernel_e;

   typedef logic signed [2:0] weights_t [0:8];

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam weights_t GX_W = '{
      -3'sd1, 3'sd0, 3'sd1,
      -3'sd2, 3'sd0, 3'sd2,
      -3'sd1, 3'sd0, 3'sd1
   };

   localparam weights_t GY_W = '{
      -3'sd1, -3'sd2, -3'sd1,
       3'sd0,  3'sd0,  3'sd0,
       3'sd1,  3'sd2,  3'sd1
   };

   localparam weights_t IDENT_W = '{
      3'sd0, 3'sd0, 3'sd0,
      3'sd0, 3'sd1, 3'sd0,
      3'sd0, 3'sd0, 3'sd0
   };

   localparam weights_t LAPL_W = '{
      3'sd0,  3'sd1, 3'sd0,
      3'sd1, -3'sd4, 3'sd1,
      3'sd0,  3'sd1, 3'sd0
   };

endpackage

// File: rtl/sobel_frame_ctrl_raster_counter.sv
// Raster (col,row) position counter with clear, enable and frame wrap.
// at_end_o flags the last position of the frame.
module raster_counter #(
   parameter int unsigned width_p  = 16,
   parameter int unsigned height_p = 16
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        clr_i,
   input  logic                        en_i,
   output logic [$clog2(width_p)-1:0]  col_o,
   output logic [$clog2(height_p)-1:0] row_o,
   output logic                        at_end_o
);

   localparam int unsigned CW = $clog2(width_p);
   localparam int unsigned RW = $clog2(height_p);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          col_end, row_end;

   assign col_end  = (col_q == CW'(width_p - 1));
   assign row_end  = (row_q == RW'(height_p - 1));
   assign at_end_o = col_end & row_end;
   assign col_o    = col_q;
   assign row_o    = row_q;

   // Next position: clear wins, otherwise step with line/frame wrap.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr_i) begin
         col_d = '0;
         row_d = '0;
      end else if (en_i) begin
         if (col_end) begin
            col_d = '0;
            row_d = row_end ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // Position registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame controller for the 3x3 sobel convolver: holds kernel weights,
// gates the pixel stream in and forwards only full-window results out.
module sobel_frame_ctrl
   import sobel_ctrl_pkg::*;
#(
   parameter int unsigned linewidth_px_p = 16,
   parameter int unsigned frame_height_p = 16,
   parameter int unsigned in_width_p     = 8,
   parameter int unsigned out_width_p    = 32
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          start_i,
   input  logic [1:0]                    kernel_i,
   output logic                          start_ready_o,
   output logic                          busy_o,
   output logic                          done_o,
   input  logic                          pix_valid_i,
   output logic                          pix_ready_o,
   input  logic [in_width_p-1:0]         pix_data_i,
   output logic                          conv_valid_o,
   input  logic                          conv_ready_i,
   output logic [in_width_p-1:0]         conv_data_o,
   output weights_t                      conv_weights_o,
   input  logic                          conv_valid_i,
   output logic                          conv_ready_o,
   input  logic signed [out_width_p-1:0] conv_data_i,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic signed [out_width_p-1:0] data_o,
   output logic                          last_o
);

   localparam int unsigned CW = $clog2(linewidth_px_p);
   localparam int unsigned RW = $clog2(frame_height_p);

   state_e  state_q, state_d;
   kernel_e kern_q, kern_d;
   logic    done_q, done_d;

   logic [CW-1:0] in_col, out_col;
   logic [RW-1:0] in_row, out_row;
   logic          in_end, out_end;
   logic          start_hs, run, active;
   logic          pix_hs, out_hs, keep, last_hs;

   assign run      = (state_q == RUN);
   assign active   = (state_q != IDLE);
   assign start_hs = (state_q == IDLE) & start_i;
   assign pix_hs   = run & pix_valid_i & conv_ready_i;
   assign out_hs   = active & conv_valid_i & conv_ready_o;
   assign keep     = (out_row >= RW'(2)) && (out_col >= CW'(2));
   assign last_hs  = out_hs & last_o;

   assign start_ready_o = (state_q == IDLE);
   assign busy_o        = active;
   assign done_o        = done_q;

   assign conv_valid_o = run & pix_valid_i;
   assign pix_ready_o  = run & conv_ready_i;
   assign conv_data_o  = pix_data_i;

   assign conv_ready_o = active & (keep ? ready_i : 1'b1);
   assign valid_o      = active & keep & conv_valid_i;
   assign data_o       = conv_data_i;
   assign last_o       = keep & out_end;

   raster_counter #(
      .width_p  (linewidth_px_p),
      .height_p (frame_height_p)
   ) u_in_cnt (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .clr_i    (start_hs),
      .en_i     (pix_hs),
      .col_o    (in_col),
      .row_o    (in_row),
      .at_end_o (in_end)
   );

   raster_counter #(
      .width_p  (linewidth_px_p),
      .height_p (frame_height_p)
   ) u_out_cnt (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .clr_i    (start_hs),
      .en_i     (out_hs),
      .col_o    (out_col),
      .row_o    (out_row),
      .at_end_o (out_end)
   );

   // Weights follow the latched kernel, so they only move on a start.
   always_comb begin
      conv_weights_o = GX_W;
      case (kern_q)
         K_GY:    conv_weights_o = GY_W;
         K_IDENT: conv_weights_o = IDENT_W;
         K_LAPL:  conv_weights_o = LAPL_W;
         default: conv_weights_o = GX_W;
      endcase
   end

   // Frame FSM: accept start, stream the frame, drain the last result.
   always_comb begin
      state_d = state_q;
      kern_d  = kern_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               kern_d  = kernel_e'(kernel_i);
               state_d = RUN;
            end
         end
         RUN: begin
            if (pix_hs && in_end) state_d = DRAIN;
         end
         DRAIN: begin
            if (last_hs) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
         kern_q  <= K_GX;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kern_q  <= kern_d;
         done_q  <= done_d;
      end
   end

   logic unused_in_pos;
   assign unused_in_pos = ^{in_col, in_row};

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench: behavioural convolver stand-in plus a frame-level
// reference built directly from the kernel tables and the pixel array.
module tb_sobel_frame_ctrl;
   import sobel_ctrl_pkg::*;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int IW = 8;
   localparam int OW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 reset_i, start_i, pix_valid_i, ready_i;
   logic [1:0]           kernel_i;
   logic [IW-1:0]        pix_data_i, conv_data_o;
   logic                 start_ready_o, busy_o, done_o, pix_ready_o;
   logic                 conv_valid_o, conv_ready_i, conv_valid_i;
   logic                 conv_ready_o, valid_o, last_o;
   logic signed [OW-1:0] conv_data_i, data_o;
   weights_t             wts;

   sobel_frame_ctrl #(
      .linewidth_px_p (W),
      .frame_height_p (H),
      .in_width_p     (IW),
      .out_width_p    (OW)
   ) dut (
      .clk_i          (clk),
      .reset_i        (reset_i),
      .start_i        (start_i),
      .kernel_i       (kernel_i),
      .start_ready_o  (start_ready_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .pix_valid_i    (pix_valid_i),
      .pix_ready_o    (pix_ready_o),
      .pix_data_i     (pix_data_i),
      .conv_valid_o   (conv_valid_o),
      .conv_ready_i   (conv_ready_i),
      .conv_data_o    (conv_data_o),
      .conv_weights_o (wts),
      .conv_valid_i   (conv_valid_i),
      .conv_ready_o   (conv_ready_o),
      .conv_data_i    (conv_data_i),
      .valid_o        (valid_o),
      .ready_i        (ready_i),
      .data_o         (data_o),
      .last_o         (last_o)
   );

   int KW [4][9] = '{
      '{-1, 0, 1, -2, 0, 2, -1, 0, 1},
      '{-1, -2, -1, 0, 0, 0, 1, 2, 1},
      '{0, 0, 0, 0, 1, 0, 0, 0, 0},
      '{0, 1, 0, 1, -4, 1, 0, 1, 0}
   };

   // Convolver stand-in: line history, one-cycle registered result.
   logic [IW-1:0]        sr [0:2*W+1];
   logic                 cv_q;
   logic signed [OW-1:0] cd_q;

   assign conv_ready_i = !cv_q || conv_ready_o;
   assign conv_valid_i = cv_q;
   assign conv_data_i  = cd_q;

   function automatic int conv_sum();
      int acc, d, pv;
      acc = 0;
      for (int k = 0; k < 9; k++) begin
         d  = (2 - k / 3) * W + (2 - k % 3);
         pv = (d == 0) ? int'(conv_data_o) : int'(sr[d-1]);
         acc += int'(wts[k]) * pv;
      end
      return acc;
   endfunction

   always @(posedge clk) begin
      if (!reset_i) begin
         cv_q <= 1'b0;
      end else if (conv_valid_o && conv_ready_i) begin
         for (int k = 2 * W + 1; k > 0; k--) sr[k] <= sr[k-1];
         sr[0] <= conv_data_o;
         cv_q  <= 1'b1;
         cd_q  <= conv_sum();
      end else if (conv_ready_o) begin
         cv_q <= 1'b0;
      end
   end

   // Output collector and downstream ready driver.
   int  got [$];
   bit  gotl [$];
   int  prev [$];
   int  expq [$];
   int  n_done;
   bit  stall_en;
   int  fr [H][W];
   int  n_chk, n_pass;

   always @(negedge clk) begin
      if (reset_i && valid_o && ready_i) begin
         got.push_back(int'(data_o));
         gotl.push_back(last_o);
      end
      if (done_o) n_done++;
   end

   always @(posedge clk) begin
      #1;
      ready_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input string tag, input longint obs, input longint expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
   endtask

   function automatic logic [26:0] wpack();
      logic [26:0] p;
      for (int k = 0; k < 9; k++) p[k*3 +: 3] = wts[k];
      return p;
   endfunction

   function automatic logic [26:0] kpack(input int kk);
      logic [26:0] p;
      for (int k = 0; k < 9; k++) p[k*3 +: 3] = 3'(KW[kk][k]);
      return p;
   endfunction

   task automatic run_frame(input int k, input int pat,
                            input bit stall, input bit mid);
      int to, s;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            case (pat)
               0: fr[r][c] = r * W + c;
               1: fr[r][c] = c;
               2: fr[r][c] = r;
               3: fr[r][c] = 7;
               4: fr[r][c] = int'($urandom_range(0, 255));
               default: ;
            endcase
      expq.delete();
      for (int r = 2; r < H; r++)
         for (int c = 2; c < W; c++) begin
            s = 0;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  s += KW[k][3*i+j] * fr[r-2+i][c-2+j];
            expq.push_back(s);
         end
      got.delete();
      gotl.delete();
      n_done   = 0;
      stall_en = stall;
      start_i  = 1'b1;
      kernel_i = 2'(k);
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("busy_after_start", busy_o, 1);
      chk("weights_start", wpack(), kpack(k));
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            if (mid && r == 2 && c == 0) begin
               start_i  = 1'b1;
               kernel_i = 2'(k + 1);
            end
            if (stall)
               while ($urandom_range(0, 2) == 0) begin
                  pix_valid_i = 1'b0;
                  @(posedge clk); #1;
               end
            pix_valid_i = 1'b1;
            pix_data_i  = IW'(fr[r][c]);
            to = 0;
            do begin
               @(negedge clk);
               to++;
            end while (!pix_ready_o && to < 1000);
            if (!pix_ready_o) chk("pix_timeout", 0, 1);
            @(posedge clk); #1;
         end
      pix_valid_i = 1'b0;
      if (mid) begin
         chk("weights_hold", wpack(), kpack(k));
         chk("busy_mid_start", busy_o, 1);
         start_i = 1'b0;
      end
      to = 0;
      do begin
         @(negedge clk);
         to++;
      end while (!done_o && to < 2000);
      chk("done_seen", done_o, 1);
      chk("busy_at_done", busy_o, 0);
      chk("start_ready_at_done", start_ready_o, 1);
      @(posedge clk); #1;
      stall_en = 1'b0;
      @(negedge clk);
      chk("done_once", n_done, 1);
      chk("result_count", got.size(), expq.size());
      for (int i = 0; i < expq.size() && i < got.size(); i++) begin
         chk("result_value", got[i], expq[i]);
         chk("result_last", gotl[i], (i == expq.size() - 1));
      end
      @(posedge clk); #1;
   endtask

   initial begin
      n_chk       = 0;
      n_pass      = 0;
      n_done      = 0;
      stall_en    = 1'b0;
      ready_i     = 1'b1;
      reset_i     = 1'b0;
      start_i     = 1'b0;
      kernel_i    = 2'd3;
      pix_valid_i = 1'b1;
      pix_data_i  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_start_ready", start_ready_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_pix_ready", pix_ready_o, 0);
      chk("rst_conv_valid", conv_valid_o, 0);
      chk("rst_weights", wpack(), kpack(0));
      reset_i     = 1'b1;
      pix_valid_i = 1'b0;
      @(posedge clk); #1;

      run_frame(2, 0, 1'b0, 1'b0);
      run_frame(0, 1, 1'b0, 1'b0);
      run_frame(1, 2, 1'b0, 1'b0);
      run_frame(3, 3, 1'b0, 1'b0);

      run_frame(0, 4, 1'b0, 1'b0);
      prev = got;
      run_frame(0, 5, 1'b1, 1'b0);
      chk("stall_count", got.size(), prev.size());
      for (int i = 0; i < prev.size() && i < got.size(); i++)
         chk("stall_same", got[i], prev[i]);

      run_frame(0, 4, 1'b0, 1'b0);
      chk("weights_after_done", wpack(), kpack(0));
      run_frame(1, 4, 1'b0, 1'b0);

      run_frame(0, 4, 1'b0, 1'b1);

      start_i  = 1'b1;
      kernel_i = 2'd3;
      @(posedge clk); #1;
      start_i     = 1'b0;
      pix_valid_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         pix_data_i = IW'($urandom_range(0, 255));
         @(posedge clk); #1;
      end
      chk("pre_reset_busy", busy_o, 1);
      reset_i = 1'b0;
      @(posedge clk); #1;
      chk("midrst_busy", busy_o, 0);
      chk("midrst_valid", valid_o, 0);
      chk("midrst_start_ready", start_ready_o, 1);
      chk("midrst_done", done_o, 0);
      chk("midrst_weights", wpack(), kpack(0));
      reset_i     = 1'b1;
      pix_valid_i = 1'b0;
      @(posedge clk); #1;
      run_frame(3, 4, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
